// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use stall, flush/hold control and bubble counter
module id_ex_stage #(
  parameter int DW    = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [1:0]       id_ALUSrc,
  input  logic [1:0]       id_MemtoReg,
  input  logic [1:0]       id_NPCOp,
  input  logic [1:0]       id_RegDst,
  input  logic             id_RegWrite,
  input  logic             id_MemRead,
  input  logic             id_MemWrite,
  input  logic [4:0]       id_ALUOp,
  input  logic [DW-1:0]    id_pc4,
  input  logic [DW-1:0]    id_rd1,
  input  logic [DW-1:0]    id_rd2,
  input  logic [DW-1:0]    id_imm,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic [4:0]       id_rd,
  input  logic [4:0]       id_shamt,
  input  logic             flush_i,
  input  logic             hold_i,
  output logic             ex_valid,
  output logic [1:0]       ex_ALUSrc,
  output logic [1:0]       ex_MemtoReg,
  output logic [1:0]       ex_NPCOp,
  output logic [1:0]       ex_RegDst,
  output logic             ex_RegWrite,
  output logic             ex_MemRead,
  output logic             ex_MemWrite,
  output logic [4:0]       ex_ALUOp,
  output logic [DW-1:0]    ex_pc4,
  output logic [DW-1:0]    ex_rd1,
  output logic [DW-1:0]    ex_rd2,
  output logic [DW-1:0]    ex_imm,
  output logic [4:0]       ex_rs,
  output logic [4:0]       ex_rt,
  output logic [4:0]       ex_rd,
  output logic [4:0]       ex_shamt,
  output logic             stall_o,
  output logic [CNT_W-1:0] bubble_cnt
);
  typedef struct packed {
    logic          valid;
    logic [1:0]    alusrc;
    logic [1:0]    memtoreg;
    logic [1:0]    npcop;
    logic [1:0]    regdst;
    logic          regwrite;
    logic          memread;
    logic          memwrite;
    logic [4:0]    aluop;
    logic [DW-1:0] pc4;
    logic [DW-1:0] rd1;
    logic [DW-1:0] rd2;
    logic [DW-1:0] imm;
    logic [4:0]    rs;
    logic [4:0]    rt;
    logic [4:0]    rd;
    logic [4:0]    shamt;
  } ex_t;
  ex_t              r_ex;
  ex_t              w_id;
  logic [CNT_W-1:0] r_cnt;
  logic             w_load_use;
  logic             w_bubble;
  // Gather ID fields; don't-care decoder controls have unknown bits forced to 0
  always_comb begin
    w_id = {id_valid, id_ALUSrc, id_MemtoReg, id_NPCOp, id_RegDst, id_RegWrite, id_MemRead,
            id_MemWrite, id_ALUOp, id_pc4, id_rd1, id_rd2, id_imm, id_rs, id_rt, id_rd, id_shamt};
    for (int i = 0; i < 2; i++) begin
      w_id.alusrc[i]   = (id_ALUSrc[i] === 1'b1);
      w_id.memtoreg[i] = (id_MemtoReg[i] === 1'b1);
      w_id.regdst[i]   = (id_RegDst[i] === 1'b1);
    end
    for (int i = 0; i < 5; i++) w_id.aluop[i] = (id_ALUOp[i] === 1'b1);
  end
  assign w_load_use = r_ex.valid & r_ex.memread & (r_ex.rt != 5'd0) & id_valid &
                      ((r_ex.rt == id_rs) | (r_ex.rt == id_rt));
  assign stall_o    = w_load_use | hold_i;
  assign w_bubble   = flush_i | (~hold_i & w_load_use);
  // Pipeline register: flush > hold > load-use bubble > load (invalid ID loads a bubble)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_ex <= '0;
    else if (w_bubble || (!hold_i && !id_valid)) r_ex <= '0;
    else if (!hold_i) r_ex <= w_id;
  end
  // Saturating count of inserted bubbles (flush or load-use)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_cnt <= '0;
    else if (w_bubble && r_cnt != '1) r_cnt <= r_cnt + 1'b1;
  end
  assign ex_valid    = r_ex.valid;
  assign ex_ALUSrc   = r_ex.alusrc;
  assign ex_MemtoReg = r_ex.memtoreg;
  assign ex_NPCOp    = r_ex.npcop;
  assign ex_RegDst   = r_ex.regdst;
  assign ex_RegWrite = r_ex.regwrite;
  assign ex_MemRead  = r_ex.memread;
  assign ex_MemWrite = r_ex.memwrite;
  assign ex_ALUOp    = r_ex.aluop;
  assign ex_pc4      = r_ex.pc4;
  assign ex_rd1      = r_ex.rd1;
  assign ex_rd2      = r_ex.rd2;
  assign ex_imm      = r_ex.imm;
  assign ex_rs       = r_ex.rs;
  assign ex_rt       = r_ex.rt;
  assign ex_rd       = r_ex.rd;
  assign ex_shamt    = r_ex.shamt;
  assign bubble_cnt  = r_cnt;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed table, corner sequences and random stimulus against a reference model
module tb_id_ex_stage;
  typedef struct packed {
    logic        valid;
    logic [1:0]  alusrc;
    logic [1:0]  memtoreg;
    logic [1:0]  npcop;
    logic [1:0]  regdst;
    logic        regwrite;
    logic        memread;
    logic        memwrite;
    logic [4:0]  aluop;
    logic [31:0] pc4;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
  } in_t;
  typedef struct {
    logic        valid, memread;
    logic [4:0]  rs, rt, op;
    logic [31:0] rd1;
    logic        flush, hold, e_stall, e_valid;
    logic [4:0]  e_op;
    logic [31:0] e_rd1;
    logic [15:0] e_cnt;
  } vec_t;
  logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0, hold = 1'b0;
  in_t cur = '0, got, m_ex = '0, snap;
  logic [15:0] m_cnt = '0, cnt_snap;
  logic stall_o;
  logic [15:0] bubble_cnt;
  logic ex_valid, ex_RegWrite, ex_MemRead, ex_MemWrite;
  logic [1:0] ex_ALUSrc, ex_MemtoReg, ex_NPCOp, ex_RegDst;
  logic [4:0] ex_ALUOp, ex_rs, ex_rt, ex_rd, ex_shamt;
  logic [31:0] ex_pc4, ex_rd1, ex_rd2, ex_imm;
  int n_cmp = 0, n_bad = 0;
  vec_t tbl[9];
  always #5 clk = ~clk;
  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .id_valid(cur.valid), .id_ALUSrc(cur.alusrc),
    .id_MemtoReg(cur.memtoreg), .id_NPCOp(cur.npcop), .id_RegDst(cur.regdst),
    .id_RegWrite(cur.regwrite), .id_MemRead(cur.memread), .id_MemWrite(cur.memwrite),
    .id_ALUOp(cur.aluop), .id_pc4(cur.pc4), .id_rd1(cur.rd1), .id_rd2(cur.rd2),
    .id_imm(cur.imm), .id_rs(cur.rs), .id_rt(cur.rt), .id_rd(cur.rd), .id_shamt(cur.shamt),
    .flush_i(flush), .hold_i(hold), .ex_valid(ex_valid), .ex_ALUSrc(ex_ALUSrc),
    .ex_MemtoReg(ex_MemtoReg), .ex_NPCOp(ex_NPCOp), .ex_RegDst(ex_RegDst),
    .ex_RegWrite(ex_RegWrite), .ex_MemRead(ex_MemRead), .ex_MemWrite(ex_MemWrite),
    .ex_ALUOp(ex_ALUOp), .ex_pc4(ex_pc4), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_shamt(ex_shamt),
    .stall_o(stall_o), .bubble_cnt(bubble_cnt)
  );
  assign got = {ex_valid, ex_ALUSrc, ex_MemtoReg, ex_NPCOp, ex_RegDst, ex_RegWrite, ex_MemRead,
                ex_MemWrite, ex_ALUOp, ex_pc4, ex_rd1, ex_rd2, ex_imm, ex_rs, ex_rt, ex_rd, ex_shamt};
  task automatic chk(input string name, input logic [199:0] act, input logic [199:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic logic m_lu();
    return m_ex.valid && m_ex.memread && m_ex.rt != 5'd0 && cur.valid === 1'b1 &&
           (m_ex.rt == cur.rs || m_ex.rt == cur.rt);
  endfunction
  function automatic in_t scrub(input in_t v);
    in_t s = v;
    for (int i = 0; i < 2; i++) begin
      if (v.alusrc[i] !== 1'b1) s.alusrc[i] = 1'b0;
      if (v.memtoreg[i] !== 1'b1) s.memtoreg[i] = 1'b0;
      if (v.regdst[i] !== 1'b1) s.regdst[i] = 1'b0;
    end
    for (int i = 0; i < 5; i++) if (v.aluop[i] !== 1'b1) s.aluop[i] = 1'b0;
    return s;
  endfunction
  task automatic edge_step();
    in_t nx = m_ex;
    logic b = 1'b0;
    if (flush) begin nx = '0; b = 1'b1; end
    else if (hold) nx = m_ex;
    else if (m_lu()) begin nx = '0; b = 1'b1; end
    else nx = cur.valid ? scrub(cur) : '0;
    @(posedge clk);
    #1;
    m_ex = nx;
    if (b && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
  endtask
  task automatic cycle(input string tag);
    #1;
    chk({tag, " stall"}, stall_o, m_lu() || hold);
    edge_step();
    chk({tag, " ex"}, got, m_ex);
    chk({tag, " cnt"}, bubble_cnt, m_cnt);
  endtask
  initial begin
    tbl[0] = '{1, 0, 4, 0, 3, 32'h1234_5678, 0, 0, 0, 1, 3, 32'h1234_5678, 0};
    tbl[1] = '{1, 1, 1, 8, 1, 32'hA, 0, 0, 0, 1, 1, 32'hA, 0};
    tbl[2] = '{1, 0, 8, 2, 2, 32'hB, 0, 0, 1, 0, 0, 32'h0, 1};
    tbl[3] = '{1, 0, 8, 2, 2, 32'hB, 0, 0, 0, 1, 2, 32'hB, 1};
    tbl[4] = '{1, 1, 0, 0, 4, 32'hC, 0, 0, 0, 1, 4, 32'hC, 1};
    tbl[5] = '{1, 0, 0, 0, 5, 32'hD, 0, 0, 0, 1, 5, 32'hD, 1};
    tbl[6] = '{1, 1, 3, 8, 6, 32'hE, 0, 0, 0, 1, 6, 32'hE, 1};
    tbl[7] = '{1, 0, 8, 1, 9, 32'h1, 1, 1, 1, 0, 0, 32'h0, 2};
    tbl[8] = '{0, 0, 0, 0, 7, 32'hF, 0, 0, 0, 0, 0, 32'h0, 2};
    #12;
    chk("reset ex", got, 200'd0);
    chk("reset cnt", bubble_cnt, 16'd0);
    chk("reset stall", stall_o, 1'b0);
    rst_n = 1'b1;
    foreach (tbl[k]) begin
      cur = '0;
      cur.valid = tbl[k].valid; cur.regwrite = 1'b1; cur.memread = tbl[k].memread;
      cur.rs = tbl[k].rs; cur.rt = tbl[k].rt; cur.aluop = tbl[k].op; cur.rd1 = tbl[k].rd1;
      flush = tbl[k].flush; hold = tbl[k].hold;
      #1;
      chk($sformatf("tbl%0d stall", k), stall_o, tbl[k].e_stall);
      edge_step();
      chk($sformatf("tbl%0d valid", k), ex_valid, tbl[k].e_valid);
      chk($sformatf("tbl%0d regwrite", k), ex_RegWrite, tbl[k].e_valid);
      chk($sformatf("tbl%0d aluop", k), ex_ALUOp, tbl[k].e_op);
      chk($sformatf("tbl%0d rd1", k), ex_rd1, tbl[k].e_rd1);
      chk($sformatf("tbl%0d cnt", k), bubble_cnt, tbl[k].e_cnt);
      chk($sformatf("tbl%0d model", k), got, m_ex);
    end
    flush = 0; hold = 0;
    cur = '0; cur.valid = 1; cur.memread = 1; cur.rt = 5'd8; cur.rd2 = 32'hCAFE; cur.aluop = 5'd11;
    cycle("hold load");
    snap = m_ex; cnt_snap = m_cnt;
    for (int i = 0; i < 3; i++) begin
      cur = in_t'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
      cur.valid = 1; cur.rs = 5'd8;
      hold = 1;
      cycle($sformatf("hold%0d", i));
      chk($sformatf("hold%0d frozen", i), got, snap);
      chk($sformatf("hold%0d cnt", i), bubble_cnt, cnt_snap);
    end
    #2 rst_n = 0;
    #1;
    chk("async rst ex", got, 200'd0);
    chk("async rst cnt", bubble_cnt, 16'd0);
    chk("rst stall hold", stall_o, 1'b1);
    hold = 0; m_ex = '0; m_cnt = '0;
    #1 chk("rst stall", stall_o, 1'b0);
    @(posedge clk); #1;
    chk("rst held ex", got, 200'd0);
    rst_n = 1;
    cur = '0; cur.valid = 1; cur.aluop = 5'd21; cur.imm = 32'hBEEF;
    cycle("post rst load");
    chk("post rst valid", ex_valid, 1'b1);
    cur = '0; cur.valid = 1; cur.memwrite = 1; cur.regdst = 'x; cur.memtoreg = 'x; cur.rd2 = 32'h55;
    cycle("xscrub");
    chk("xscrub regdst", ex_RegDst, 2'b00);
    chk("xscrub memtoreg", ex_MemtoReg, 2'b00);
    chk("xscrub memwrite", ex_MemWrite, 1'b1);
    for (int i = 0; i < 300; i++) begin
      cur = in_t'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
      cur.valid = ($urandom_range(0, 7) != 0);
      cur.rs = 5'($urandom_range(0, 3)); cur.rt = 5'($urandom_range(0, 3));
      flush = ($urandom_range(0, 7) == 0); hold = ($urandom_range(0, 5) == 0);
      cycle($sformatf("rnd%0d", i));
    end
    hold = 0; flush = 1;
    for (int i = 0; i < 65535; i++) edge_step();
    chk("sat reach", bubble_cnt, m_cnt);
    chk("sat value", bubble_cnt, 16'hFFFF);
    cycle("sat hold");
    chk("sat stays", bubble_cnt, 16'hFFFF);
    #2 rst_n = 0;
    #1;
    chk("sat rst cnt", bubble_cnt, 16'd0);
    chk("sat rst ex", got, 200'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
